// File: rtl/branch_predictor_if.sv
// Fetch/decode-side signal bundle for the branch predictor.
// Latency: none (wires only).
// Backpressure: stall_d/flush_d travel inside the bundle; there is no handshake.
interface branch_predictor_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      pc_f;
    logic             is_branch_f;
    logic             pred_taken_f;
    logic             stall_d;
    logic             flush_d;
    logic             branch_d;
    logic             taken_d;
    logic             pred_taken_d;
    logic             mispredict_d;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] miss_cnt;

    // Pipeline side: drives fetch/decode information, consumes predictions.
    modport master (
        output pc_f, is_branch_f, stall_d, flush_d, branch_d, taken_d,
        input  pred_taken_f, pred_taken_d, mispredict_d, branch_cnt, miss_cnt
    );

    // Predictor side.
    modport slave (
        input  pc_f, is_branch_f, stall_d, flush_d, branch_d, taken_d,
        output pred_taken_f, pred_taken_d, mispredict_d, branch_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch predictor; optional gshare via BRANCH_PREDICTOR_GSHARE_EN.
// Latency: prediction combinational at fetch; training visible to fetch one cycle after the update edge.
// Backpressure: stall_d holds the fetch->decode prediction and defers training; flush_d kills it.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int GHR_W = 6,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    branch_predictor_if.slave bp
);
    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0]       ctr [DEPTH];
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] idx_f;
    logic             valid_d;
    logic             pred_d;
    logic [IDX_W-1:0] idx_d;
    logic             update;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;
    logic             unused_pc;

    assign pc_idx    = bp.pc_f[IDX_W+1:2];
    assign unused_pc = ^{bp.pc_f[31:IDX_W+2], bp.pc_f[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    assign idx_f = pc_idx ^ IDX_W'(ghr);

    // Global history: shift in each resolved outcome; deliberately not restored on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (update) begin
            ghr <= (ghr << 1) | GHR_W'(bp.taken_d);
        end
    end
`else
    localparam int unused_ghr_w = GHR_W;

    assign idx_f = pc_idx;
`endif

    // Training happens once per branch, at the edge closing its non-stalled decode cycle.
    assign update          = bp.branch_d & valid_d & ~bp.stall_d;
    assign bp.pred_taken_f = bp.is_branch_f & ctr[idx_f][1];
    assign bp.pred_taken_d = pred_d;
    assign bp.mispredict_d = update & (pred_d ^ bp.taken_d);
    assign bp.branch_cnt   = branch_cnt_q;
    assign bp.miss_cnt     = miss_cnt_q;

    // Counter table: all entries weak not-taken at reset; saturating train, no read bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (update) begin
            if (bp.taken_d && (ctr[idx_d] != 2'b11)) begin
                ctr[idx_d] <= ctr[idx_d] + 2'd1;
            end else if (!bp.taken_d && (ctr[idx_d] != 2'b00)) begin
                ctr[idx_d] <= ctr[idx_d] - 2'd1;
            end
        end
    end

    // Fetch->decode prediction register: flush beats stall beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_d <= 1'b0;
            pred_d  <= 1'b0;
            idx_d   <= '0;
        end else if (bp.flush_d) begin
            valid_d <= 1'b0;
            pred_d  <= 1'b0;
        end else if (!bp.stall_d) begin
            valid_d <= bp.is_branch_f;
            pred_d  <= bp.pred_taken_f;
            idx_d   <= idx_f;
        end
    end

    // Performance counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (update && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (bp.mispredict_d && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor with a behavioural reference model.
// Latency: model tracks combinational prediction and edge-time training.
// Backpressure: exercises stall, flush, stall+flush and reset mid-stall.
module tb_branch_predictor;
    localparam int IDX_W = 6;
    localparam int GHR_W = 6;
    localparam int CNT_W = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if #(.CNT_W(CNT_W)) bp_if ();

    branch_predictor #(.IDX_W(IDX_W), .GHR_W(GHR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: counters as small integers 0..3.
    int          m_ctr [DEPTH];
    bit          m_valid;
    bit          m_pred;
    int          m_idx;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    int          m_ghr;
`endif

    function automatic int m_index(input logic [31:0] pc);
        int i;
        i = int'((pc / 4) % DEPTH);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    function automatic bit m_pred_f();
        return bp_if.is_branch_f && (m_ctr[m_index(bp_if.pc_f)] >= 2);
    endfunction

    function automatic bit m_update();
        return bp_if.branch_d && m_valid && !bp_if.stall_d;
    endfunction

    function automatic bit m_mis();
        return m_update() && (m_pred != bp_if.taken_d);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
        m_valid = 0;
        m_pred  = 0;
        m_idx   = 0;
        m_bcnt  = 0;
        m_mcnt  = 0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        m_ghr   = 0;
`endif
    endtask

    task automatic drive_idle();
        bp_if.pc_f        = 32'h0;
        bp_if.is_branch_f = 1'b0;
        bp_if.stall_d     = 1'b0;
        bp_if.flush_d     = 1'b0;
        bp_if.branch_d    = 1'b0;
        bp_if.taken_d     = 1'b0;
    endtask

    // Advance one clock and move the model across the same edge.
    task automatic step();
        bit upd, mis, pf, tk, fl, st, isb;
        int ix;
        upd = m_update();
        mis = m_mis();
        pf  = m_pred_f();
        ix  = m_index(bp_if.pc_f);
        tk  = bp_if.taken_d;
        fl  = bp_if.flush_d;
        st  = bp_if.stall_d;
        isb = bp_if.is_branch_f;
        @(posedge clk);
        if (upd) begin
            if (tk) m_ctr[m_idx] = (m_ctr[m_idx] == 3) ? 3 : m_ctr[m_idx] + 1;
            else    m_ctr[m_idx] = (m_ctr[m_idx] == 0) ? 0 : m_ctr[m_idx] - 1;
            if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
            if (mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
            m_ghr = ((m_ghr << 1) | int'(tk)) % DEPTH;
`endif
        end
        if (fl) begin
            m_valid = 0;
            m_pred  = 0;
        end else if (!st) begin
            m_valid = isb;
            m_pred  = pf;
            m_idx   = ix;
        end
        #2;
    endtask

    // One fetch cycle followed by one resolving decode cycle for the same branch.
    task automatic visit(input logic [31:0] pc, input bit tk,
                         output bit got_pf, output bit exp_pf,
                         output bit got_mis, output bit exp_mis);
        bp_if.is_branch_f = 1'b1;
        bp_if.pc_f        = pc;
        bp_if.branch_d    = 1'b0;
        #1;
        got_pf = bp_if.pred_taken_f;
        exp_pf = m_pred_f();
        step();
        bp_if.is_branch_f = 1'b0;
        bp_if.branch_d    = 1'b1;
        bp_if.taken_d     = tk;
        #1;
        got_mis = bp_if.mispredict_d;
        exp_mis = m_mis();
        step();
        bp_if.branch_d = 1'b0;
        bp_if.taken_d  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        #7;
        n_cmp++;
        if (bp_if.pred_taken_d !== 1'b0) begin n_bad++; $display("FAIL reset_pred_d: got %0d want 0", bp_if.pred_taken_d); end
        n_cmp++;
        if (bp_if.mispredict_d !== 1'b0) begin n_bad++; $display("FAIL reset_mis: got %0d want 0", bp_if.mispredict_d); end
        n_cmp++;
        if (bp_if.branch_cnt !== 32'd0 || bp_if.miss_cnt !== 32'd0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bp_if.branch_cnt, bp_if.miss_cnt);
        end
        rst = 1'b0;
        bp_if.is_branch_f = 1'b1;
        bp_if.pc_f        = 32'h0040_0010;
        #1;
        n_cmp++;
        if (bp_if.pred_taken_f !== 1'b0) begin n_bad++; $display("FAIL reset_pred_f: got %0d want 0", bp_if.pred_taken_f); end
        step();
        n_cmp++;
        if (bp_if.pred_taken_d !== 1'b0) begin n_bad++; $display("FAIL first_pred_d: got %0d want 0", bp_if.pred_taken_d); end
    endtask

    // The branch fetched in test_reset is now in decode.
    task automatic test_train();
        bit gp, ep, gm, em, want;
        bp_if.is_branch_f = 1'b0;
        bp_if.branch_d    = 1'b1;
        bp_if.taken_d     = 1'b1;
        #1;
        n_cmp++;
        if (bp_if.mispredict_d !== 1'b1) begin n_bad++; $display("FAIL train_first_mis: got %0d want 1", bp_if.mispredict_d); end
        step();
        bp_if.branch_d = 1'b0;
        visit(32'h0040_0010, 1'b1, gp, ep, gm, em);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        want = ep;
`else
        want = 1'b1;
`endif
        n_cmp++;
        if (gp !== want) begin n_bad++; $display("FAIL train_second_pred: got %0d want %0d", gp, want); end
        n_cmp++;
        if (gm !== (want ? 1'b0 : 1'b1) || gm !== em) begin n_bad++; $display("FAIL train_second_mis: got %0d want %0d", gm, em); end
        #1;
        n_cmp++;
        if (bp_if.branch_cnt !== 32'd2) begin n_bad++; $display("FAIL train_bcnt: got %0d want 2", bp_if.branch_cnt); end
        n_cmp++;
        if (bp_if.miss_cnt !== m_mcnt) begin n_bad++; $display("FAIL train_mcnt: got %0d want %0d", bp_if.miss_cnt, m_mcnt); end
    endtask

    task automatic test_saturation();
        bit gp, ep, gm, em, want;
        bit tbl [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            visit(32'h0040_0020, (i < 5), gp, ep, gm, em);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
            want = ep;
`else
            want = tbl[i];
`endif
            n_cmp++;
            if (gp !== want) begin n_bad++; $display("FAIL sat_pred[%0d]: got %0d want %0d", i, gp, want); end
            n_cmp++;
            if (gm !== em) begin n_bad++; $display("FAIL sat_mis[%0d]: got %0d want %0d", i, gm, em); end
        end
        bp_if.is_branch_f = 1'b1;
        bp_if.pc_f        = 32'h0040_0020;
        #1;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        want = m_pred_f();
`else
        want = 1'b0;
`endif
        n_cmp++;
        if (bp_if.pred_taken_f !== want) begin n_bad++; $display("FAIL sat_final_pred: got %0d want %0d", bp_if.pred_taken_f, want); end
        bp_if.is_branch_f = 1'b0;
        step();
    endtask

    task automatic test_stall();
        logic [31:0] b0;
        bit held;
        bp_if.is_branch_f = 1'b1;
        bp_if.pc_f        = 32'h0040_0010;
        step();
        held = m_pred;
        b0   = m_bcnt;
        bp_if.branch_d    = 1'b1;
        bp_if.taken_d     = 1'b0;
        bp_if.stall_d     = 1'b1;
        bp_if.pc_f        = 32'h0040_0024;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (bp_if.pred_taken_d !== held || bp_if.mispredict_d !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got pred %0d mis %0d want %0d/0", i, bp_if.pred_taken_d, bp_if.mispredict_d, held);
            end
            step();
            n_cmp++;
            if (bp_if.branch_cnt !== b0) begin n_bad++; $display("FAIL stall_bcnt[%0d]: got %0d want %0d", i, bp_if.branch_cnt, b0); end
        end
        bp_if.stall_d = 1'b0;
        #1;
        n_cmp++;
        if (bp_if.mispredict_d !== m_mis()) begin n_bad++; $display("FAIL stall_release_mis: got %0d want %0d", bp_if.mispredict_d, m_mis()); end
        step();
        drive_idle();
        n_cmp++;
        if (bp_if.branch_cnt !== b0 + 32'd1) begin n_bad++; $display("FAIL stall_release_bcnt: got %0d want %0d", bp_if.branch_cnt, b0 + 32'd1); end
        step();
    endtask

    task automatic test_flush();
        logic [31:0] b0;
        bp_if.is_branch_f = 1'b1;
        bp_if.pc_f        = 32'h0040_0010;
        step();
        bp_if.is_branch_f = 1'b0;
        bp_if.flush_d     = 1'b1;
        bp_if.stall_d     = 1'b1;
        step();
        bp_if.flush_d  = 1'b0;
        bp_if.stall_d  = 1'b0;
        bp_if.branch_d = 1'b1;
        bp_if.taken_d  = 1'b1;
        b0 = m_bcnt;
        #1;
        n_cmp++;
        if (bp_if.pred_taken_d !== 1'b0) begin n_bad++; $display("FAIL flush_pred_d: got %0d want 0", bp_if.pred_taken_d); end
        n_cmp++;
        if (bp_if.mispredict_d !== 1'b0) begin n_bad++; $display("FAIL flush_mis: got %0d want 0", bp_if.mispredict_d); end
        step();
        drive_idle();
        n_cmp++;
        if (bp_if.branch_cnt !== b0) begin n_bad++; $display("FAIL flush_bcnt: got %0d want %0d", bp_if.branch_cnt, b0); end
    endtask

    task automatic test_reset_mid_stall();
        bit gp, ep, gm, em;
        for (int i = 0; i < 3; i++) visit(32'h0040_0040, 1'b1, gp, ep, gm, em);
        bp_if.is_branch_f = 1'b1;
        bp_if.pc_f        = 32'h0040_0040;
        step();
        bp_if.is_branch_f = 1'b0;
        bp_if.branch_d    = 1'b1;
        bp_if.taken_d     = 1'b0;
        bp_if.stall_d     = 1'b1;
        step();
        n_cmp++;
        if (bp_if.pred_taken_d !== m_pred) begin n_bad++; $display("FAIL rst_pre_pred_d: got %0d want %0d", bp_if.pred_taken_d, m_pred); end
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (bp_if.pred_taken_d !== 1'b0 || bp_if.mispredict_d !== 1'b0) begin
            n_bad++; $display("FAIL rst_async_out: got pred %0d mis %0d want 0/0", bp_if.pred_taken_d, bp_if.mispredict_d);
        end
        n_cmp++;
        if (bp_if.branch_cnt !== 32'd0 || bp_if.miss_cnt !== 32'd0) begin
            n_bad++; $display("FAIL rst_async_cnt: got %0d/%0d want 0/0", bp_if.branch_cnt, bp_if.miss_cnt);
        end
        rst = 1'b0;
        drive_idle();
        bp_if.is_branch_f = 1'b1;
        bp_if.pc_f        = 32'h0040_0040;
        #1;
        n_cmp++;
        if (bp_if.pred_taken_f !== 1'b0) begin n_bad++; $display("FAIL rst_entry_pred: got %0d want 0", bp_if.pred_taken_f); end
        drive_idle();
        step();
    endtask

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    task automatic test_gshare();
        bit gp, ep, gm, em;
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
        drive_idle();
        visit(32'h0040_0004, 1'b1, gp, ep, gm, em);
        bp_if.is_branch_f = 1'b1;
        bp_if.pc_f        = 32'h0040_0010;
        #1;
        n_cmp++;
        if (bp_if.pred_taken_f !== 1'b0) begin n_bad++; $display("FAIL gshare_idx4_pred: got %0d want 0", bp_if.pred_taken_f); end
        step();
        bp_if.is_branch_f = 1'b0;
        bp_if.branch_d    = 1'b1;
        bp_if.taken_d     = 1'b1;
        step();
        drive_idle();
        bp_if.is_branch_f = 1'b1;
        bp_if.pc_f        = 32'h0040_0018;
        #1;
        n_cmp++;
        if (bp_if.pred_taken_f !== 1'b1) begin n_bad++; $display("FAIL gshare_entry5_trained: got %0d want 1", bp_if.pred_taken_f); end
        bp_if.pc_f = 32'h0040_001C;
        #1;
        n_cmp++;
        if (bp_if.pred_taken_f !== 1'b0) begin n_bad++; $display("FAIL gshare_entry4_untouched: got %0d want 0", bp_if.pred_taken_f); end
        drive_idle();
        step();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                n_cmp++;
                if (bp_if.branch_cnt !== 32'd0 || bp_if.pred_taken_d !== 1'b0) begin
                    n_bad++; $display("FAIL rand_rst[%0d]: got cnt %0d pred %0d want 0/0", c, bp_if.branch_cnt, bp_if.pred_taken_d);
                end
                rst = 1'b0;
            end
            bp_if.pc_f        = 32'h0040_0000 + 32'($urandom_range(0, 15)) * 32'd4;
            bp_if.is_branch_f = ($urandom_range(0, 9) < 6);
            bp_if.branch_d    = ($urandom_range(0, 9) < 7);
            bp_if.taken_d     = $urandom_range(0, 1) == 1;
            bp_if.stall_d     = ($urandom_range(0, 9) < 2);
            bp_if.flush_d     = ($urandom_range(0, 9) < 1);
            #1;
            n_cmp++;
            if (bp_if.pred_taken_f !== m_pred_f()) begin n_bad++; $display("FAIL rand_pred_f[%0d]: got %0d want %0d", c, bp_if.pred_taken_f, m_pred_f()); end
            n_cmp++;
            if (bp_if.pred_taken_d !== m_pred) begin n_bad++; $display("FAIL rand_pred_d[%0d]: got %0d want %0d", c, bp_if.pred_taken_d, m_pred); end
            n_cmp++;
            if (bp_if.mispredict_d !== m_mis()) begin n_bad++; $display("FAIL rand_mis[%0d]: got %0d want %0d", c, bp_if.mispredict_d, m_mis()); end
            n_cmp++;
            if (bp_if.branch_cnt !== m_bcnt || bp_if.miss_cnt !== m_mcnt) begin
                n_bad++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", c, bp_if.branch_cnt, bp_if.miss_cnt, m_bcnt, m_mcnt);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_train();
        test_saturation();
        test_stall();
        test_flush();
        test_reset_mid_stall();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        test_gshare();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Predicts conditional branch direction at fetch, before the decode-stage comparator resolves the outcome.
- Holds a table of 2-bit saturating counters indexed by PC.
- Carries each prediction to decode alongside the instruction, compares it with the resolved taken/not-taken result, flags mispredicts for the PC-redirect logic, and trains the table.

Parameters:
IDX_W, 6, table index width; table holds 2**IDX_W two-bit counters.
GHR_W, 6, global history width (used only with GSHARE_EN; must be <= IDX_W).
CNT_W, 32, width of the performance counters.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
pc_f  input  32  fetch-stage PC
is_branch_f  input  1  predecode: fetch instruction is BEQ/BNE/BGTZ/BLEZ/BGEZ/BLTZ/BGEZAL/BLTZAL
pred_taken_f  output  1  combinational prediction for pc_f (0 when is_branch_f=0)
stall_d  input  1  hold the fetch->decode prediction register
flush_d  input  1  clear the fetch->decode prediction register
branch_d  input  1  decode instruction is a conditional branch
taken_d  input  1  resolved outcome from the decode comparator
pred_taken_d  output  1  registered prediction for the decode instruction
mispredict_d  output  1  branch_d & valid_d & (pred_taken_d != taken_d) & ~stall_d
branch_cnt  output  CNT_W  resolved branches
miss_cnt  output  CNT_W  mispredicted branches

Behaviour:
- Index idx_f = pc_f[IDX_W+1:2]. Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Prediction: pred_taken_f = is_branch_f & counter[idx_f][1].
- Fetch->decode register: holds valid_d, pred_taken_d, idx_d.
  - Priority flush_d > stall_d > load.
  - Flush clears valid_d and pred_taken_d to 0.
  - Stall holds all three.
  - Otherwise loads valid_d<=is_branch_f, pred_taken_d<=pred_taken_f, idx_d<=idx_f.
- Update fires when branch_d & valid_d & ~stall_d. It happens exactly once per branch, at the edge ending the non-stalled decode cycle.
  - counter[idx_d] increments if taken_d=1, decrements otherwise.
  - Saturates at 11 and 00.
- Same-cycle read/write of the same index: the fetch read returns the pre-update value. There is no bypass.
- branch_d=1 with valid_d=0 (branch entered after a flush, or the predecode missed it): no update, mispredict_d=0, branch_cnt unchanged.
- Performance counters:
  - branch_cnt increments on every update.
  - miss_cnt increments when mispredict_d=1.
  - Both saturate at all-ones and do not wrap.
- Reset (asynchronous, any time including mid-stall):
  - every counter to 01;
  - valid_d, pred_taken_d, idx_d, branch_cnt, miss_cnt to 0;
  - history register to 0.
- Resulting reset output values: pred_taken_f=0 (all counters weak NT), pred_taken_d=0, mispredict_d=0, counts 0.
- Latency: prediction in 0 cycles (combinational); train visible to fetch on the cycle after the update edge.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - A GHR_W-bit global history register shifts left, inserting taken_d, on every update.
  - Index becomes pc_f[IDX_W+1:2] XOR {zero-extend, ghr}.
  - The index captured into idx_d is the XORed index used at prediction time, so training hits the predicted entry.
  - GHR resets to 0 and is not restored on flush.
- Undefined: no history register; pure PC indexing as above.

Test Plan:
1. Reset, then is_branch_f=1, pc_f=0x00400010 -> pred_taken_f=0, and pred_taken_d=0 on the next cycle.
2. Same branch resolved taken_d=1 on two consecutive visits -> first is mispredict_d=1; counter 01->10; second visit predicts taken, mispredict_d=0, counter 10->11; branch_cnt=2, miss_cnt=1.
3. Saturation: five taken updates, then one not-taken -> counter 11->10, next prediction still taken; a following not-taken -> 01, predict not-taken.
4. stall_d=1 for 3 cycles with branch_d=1 in decode -> pred_taken_d held, no counter change, branch_cnt increments by exactly 1 after stall release.
5. flush_d=1 together with stall_d=1 -> valid_d=0; subsequent branch_d=1, taken_d=1 -> mispredict_d=0, no update.
6. Assert rst mid-stall after training an entry to 11 -> outputs 0 immediately; the entry predicts not-taken (01) after reset. With BRANCH_PREDICTOR_GSHARE_EN defined: after history 000001, pc index 0x04 uses entry 0x05.
